// File: rtl/ps2_device_stimulus_if.sv
// Push port and line/status bundle for the PS/2 device stimulus model.
`timescale 1ns/1ps
interface ps2_device_stimulus_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COUNT_W    = 16
);
  logic                          push_valid;
  logic [7:0]                    push_data;
  logic                          push_bad_parity;
  logic                          push_ready;
  logic                          host_inhibit;
  logic                          ps2_clk_out;
  logic                          ps2_dat_out;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [COUNT_W-1:0]            frames_sent;

  modport master (
    output push_valid, push_data, push_bad_parity, host_inhibit,
    input  push_ready, ps2_clk_out, ps2_dat_out, busy, fifo_count, frames_sent
  );

  modport slave (
    input  push_valid, push_data, push_bad_parity, host_inhibit,
    output push_ready, ps2_clk_out, ps2_dat_out, busy, fifo_count, frames_sent
  );
endinterface

// File: rtl/ps2_device_stimulus.sv
// PS/2 device-side frame generator: queued bytes are sent as 11-bit frames with
// optional parity corruption, host-inhibit abort and retransmission.
`timescale 1ns/1ps
module ps2_device_stimulus #(
  parameter int unsigned CLK_HALF_PERIOD = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 8,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ps2_device_stimulus_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned PhW  = $clog2(CLK_HALF_PERIOD);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_HALF_PERIOD - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] Full    = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StBitHigh, StBitLow, StGap} state_e;

  state_e              state_q, state_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic [3:0]          bit_q, bit_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [8:0]          cur_q, cur_d;
  logic                retry_q, retry_d;
  logic                clk_q, clk_d;
  logic                dat_q, dat_d;
  logic [COUNT_W-1:0]  frames_q, frames_d;
  logic [PtrW-1:0]     wr_q, rd_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [8:0]          mem_q [FIFO_DEPTH];

  logic                push, pop, abort;
  logic [10:0]         frame;

  assign bus.push_ready  = (count_q != Full);
  assign bus.ps2_clk_out = clk_q;
  assign bus.ps2_dat_out = dat_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.fifo_count  = count_q;
  assign bus.frames_sent = frames_q;

  assign push    = bus.push_valid && bus.push_ready;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  // Odd parity over the data byte, optionally flipped by the stored bad-parity flag.
  assign frame = {1'b1, (~^cur_q[7:0]) ^ cur_q[8], cur_q[7:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    cur_d    = cur_q;
    retry_d  = retry_q;
    clk_d    = clk_q;
    dat_d    = dat_q;
    frames_d = frames_q;
    pop      = 1'b0;
    // Inhibit aborts only until the parity bit's falling edge has been driven.
    abort    = bus.host_inhibit &&
               (((state_q == StBitHigh) && (bit_q <= 4'd9)) ||
                ((state_q == StBitLow) && (bit_q <= 4'd8)));
    if (abort) begin
      clk_d   = 1'b1;
      dat_d   = 1'b1;
      gap_d   = '0;
      state_d = StGap;
    end else begin
      unique case (state_q)
        StIdle: begin
          clk_d = 1'b1;
          dat_d = 1'b1;
          if (!bus.host_inhibit && (retry_q || (count_q != '0))) begin
            // retry_q marks cur_q as an undelivered byte that must go out first.
            if (!retry_q) begin
              pop   = 1'b1;
              cur_d = mem_q[rd_q];
            end
            retry_d = 1'b1;
            dat_d   = 1'b0;
            bit_d   = '0;
            phase_d = '0;
            state_d = StBitHigh;
          end
        end
        StBitHigh: begin
          if (phase_q == PhLast) begin
            clk_d   = 1'b0;
            phase_d = '0;
            state_d = StBitLow;
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end
        StBitLow: begin
          if (phase_q == PhLast) begin
            clk_d   = 1'b1;
            phase_d = '0;
            if (bit_q == 4'd10) begin
              dat_d    = 1'b1;
              frames_d = frames_q + COUNT_W'(1);
              retry_d  = 1'b0;
              gap_d    = '0;
              state_d  = StGap;
            end else begin
              bit_d   = bit_q + 4'd1;
              dat_d   = frame[bit_q + 4'd1];
              state_d = StBitHigh;
            end
          end else begin
            phase_d = phase_q + PhW'(1);
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      cur_q    <= '0;
      retry_q  <= 1'b0;
      clk_q    <= 1'b1;
      dat_q    <= 1'b1;
      frames_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      cur_q    <= cur_d;
      retry_q  <= retry_d;
      clk_q    <= clk_d;
      dat_q    <= dat_d;
      frames_q <= frames_d;
      count_q  <= count_d;
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.push_bad_parity, bus.push_data};
  end

endmodule

// File: tb/tb_ps2_device_stimulus.sv
// Randomised and directed bench for ps2_device_stimulus against a frame-timeline model.
`timescale 1ns/1ps
module tb_ps2_device_stimulus;

  localparam int CHP       = 4;
  localparam int DEPTH     = 4;
  localparam int GAP       = 8;
  localparam int BitLen    = 2 * CHP;
  localparam int FrameLen  = 22 * CHP;
  localparam int LastAbort = 9 * BitLen + CHP - 1;

  logic clk;
  logic reset_n;

  ps2_device_stimulus_if #(.FIFO_DEPTH(DEPTH), .COUNT_W(16)) bus ();
  ps2_device_stimulus_if #(.FIFO_DEPTH(DEPTH), .COUNT_W(2))  bus2 ();

  assign bus2.push_valid      = bus.push_valid;
  assign bus2.push_data       = bus.push_data;
  assign bus2.push_bad_parity = bus.push_bad_parity;
  assign bus2.host_inhibit    = bus.host_inhibit;

  ps2_device_stimulus #(
    .CLK_HALF_PERIOD(CHP), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .COUNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  ps2_device_stimulus #(
    .CLK_HALF_PERIOD(CHP), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .COUNT_W(2)
  ) dut_w2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: frame position as a cycle offset into the 11-bit timeline.
  logic [8:0]  mq [$];
  int          m_mode;     // 0 idle, 1 frame, 2 gap
  int          m_t, m_g;
  logic [8:0]  m_cur;
  bit          m_pending;
  int unsigned m_frames;

  function automatic void m_clear();
    mq.delete();
    m_mode = 0; m_t = 0; m_g = 0; m_cur = '0; m_pending = 0; m_frames = 0;
  endfunction

  function automatic void m_step();
    bit ready_pre = (mq.size() < DEPTH);
    case (m_mode)
      1: begin
        if (bus.host_inhibit && m_t <= LastAbort) begin
          m_mode = 2; m_g = 0;
        end else begin
          m_t++;
          if (m_t == FrameLen) begin
            m_mode = 2; m_g = 0; m_frames++; m_pending = 0;
          end
        end
      end
      2: if (m_g == GAP - 1) m_mode = 0; else m_g++;
      default: begin
        if (!bus.host_inhibit && (m_pending || mq.size() > 0)) begin
          if (!m_pending) m_cur = mq.pop_front();
          m_pending = 1; m_mode = 1; m_t = 0;
        end
      end
    endcase
    if (bus.push_valid && ready_pre) mq.push_back({bus.push_bad_parity, bus.push_data});
  endfunction

  function automatic logic m_dat();
    int b;
    if (m_mode != 1) return 1'b1;
    b = m_t / BitLen;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (b == 9) return ((($countones(m_cur[7:0]) % 2) == 0) ? 1'b1 : 1'b0) ^ m_cur[8];
    return 1'b1;
  endfunction

  function automatic logic m_clk();
    if (m_mode != 1) return 1'b1;
    return ((m_t % BitLen) < CHP) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_clear();
      else m_step();
    end
  end

  // Compare and line monitor.
  logic       falls [$];
  int         fall_cyc [$];
  int         cyc = 0;
  int         dat_fall_cyc = 0;
  logic       prev_clk = 1'b1, prev_dat = 1'b1, prev_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset_n) begin
        check("ps2_clk_out", bus.ps2_clk_out, m_clk());
        check("ps2_dat_out", bus.ps2_dat_out, m_dat());
        check("busy", bus.busy, (m_mode != 0));
        check("fifo_count", bus.fifo_count, mq.size());
        check("push_ready", bus.push_ready, (mq.size() != DEPTH));
        check("frames_sent", bus.frames_sent, m_frames % 65536);
        check("frames_sent_w2", bus2.frames_sent, m_frames % 4);
      end
      if (prev_clk && !bus.ps2_clk_out) begin
        falls.push_back(bus.ps2_dat_out);
        fall_cyc.push_back(cyc);
      end
      if (prev_dat && !bus.ps2_dat_out && !prev_busy) dat_fall_cyc = cyc;
      prev_clk  = bus.ps2_clk_out;
      prev_dat  = bus.ps2_dat_out;
      prev_busy = bus.busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers; all are entered and left just after a falling clk edge.
  task automatic push_byte(input logic [7:0] d, input logic bad);
    int n = 0;
    while (!bus.push_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeout("push_ready");
    bus.push_valid      = 1'b1;
    bus.push_data       = d;
    bus.push_bad_parity = bad;
    @(negedge clk);
    bus.push_valid      = 1'b0;
    bus.push_bad_parity = 1'b0;
  endtask

  task automatic wait_frames(input int unsigned target, input string name);
    int n = 0;
    while (bus.frames_sent != 16'(target) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1500) timeout(name);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (falls.size() < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeout("wait_falls");
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.busy || bus.fifo_count != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeout(name);
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = falls[base + 1 + i];
    return r;
  endfunction

  task automatic check_frame_bits(input string name, input logic [10:0] exp);
    check({name, "_count"}, falls.size(), 11);
    if (falls.size() >= 11) begin
      for (int i = 0; i < 11; i++) check(name, falls[i], exp[i]);
    end
  endtask

  logic [10:0] exp_1c, exp_f0;
  logic [7:0]  five [5];
  logic [1:0]  wrap_exp [3];

  initial begin
    exp_1c = 11'b10000111000;
    exp_f0 = 11'b10111100000;
    five   = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9};
    wrap_exp = '{2'd0, 2'd1, 2'd2};

    reset_n             = 1'b0;
    bus.push_valid      = 1'b0;
    bus.push_data       = '0;
    bus.push_bad_parity = 1'b0;
    bus.host_inhibit    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk", bus.ps2_clk_out, 1);
    check("rst_dat", bus.ps2_dat_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_fifo", bus.fifo_count, 0);
    check("rst_frames", bus.frames_sent, 0);
    check("rst_ready", bus.push_ready, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x1C with correct parity: bit values and bit timing.
    falls.delete(); fall_cyc.delete();
    push_byte(8'h1C, 1'b0);
    wait_frames(1, "frame_1c");
    check_frame_bits("bits_1c", exp_1c);
    if (fall_cyc.size() >= 11) begin
      check("first_fall_delay", fall_cyc[0] - dat_fall_cyc, CHP);
      for (int i = 1; i < 11; i++) check("fall_spacing", fall_cyc[i] - fall_cyc[i-1], BitLen);
    end
    check("frames_after_1c", bus.frames_sent, 1);

    // 0xF0 with injected parity error.
    falls.delete(); fall_cyc.delete();
    push_byte(8'hF0, 1'b1);
    wait_frames(2, "frame_f0");
    check_frame_bits("bits_f0", exp_f0);
    check("frames_after_f0", bus.frames_sent, 2);

    // Five back-to-back pushes overflow into a full FIFO.
    wait_idle("idle_before_five");
    falls.delete(); fall_cyc.delete();
    for (int i = 0; i < 5; i++) push_byte(five[i], 1'b0);
    check("five_fifo_full", bus.fifo_count, 4);
    check("five_ready_low", bus.push_ready, 0);
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", bus.push_ready, 0);
    end
    bus.push_valid = 1'b0;
    wait_frames(7, "frames_five");
    check("five_fall_count", falls.size(), 55);
    if (falls.size() >= 55) begin
      for (int i = 0; i < 5; i++) check("five_order", decode(11 * i), five[i]);
    end

    // Inhibit during data bit 3 of 0x12, then retransmit ahead of 0x34.
    wait_idle("idle_before_inhibit");
    falls.delete(); fall_cyc.delete();
    push_byte(8'h12, 1'b0);
    push_byte(8'h34, 1'b0);
    wait_falls(5);
    bus.host_inhibit = 1'b1;
    @(negedge clk);
    check("abort_clk_high", bus.ps2_clk_out, 1);
    check("abort_dat_high", bus.ps2_dat_out, 1);
    check("abort_frames", bus.frames_sent, 7);
    falls.delete(); fall_cyc.delete();
    repeat (19) @(negedge clk);
    bus.host_inhibit = 1'b0;
    wait_frames(9, "frames_retry");
    check("retry_fall_count", falls.size(), 22);
    if (falls.size() >= 22) begin
      check("retry_first", decode(0), 8'h12);
      check("retry_second", decode(11), 8'h34);
    end

    // Reset mid-frame with two bytes queued.
    wait_idle("idle_before_reset");
    falls.delete(); fall_cyc.delete();
    push_byte(8'hAA, 1'b0);
    push_byte(8'h55, 1'b0);
    push_byte(8'h0F, 1'b0);
    wait_falls(3);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_clk", bus.ps2_clk_out, 1);
    check("midrst_dat", bus.ps2_dat_out, 1);
    check("midrst_fifo", bus.fifo_count, 0);
    check("midrst_frames", bus.frames_sent, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    falls.delete(); fall_cyc.delete();
    repeat (150) @(negedge clk);
    check("post_rst_no_frame", falls.size(), 0);
    check("post_rst_idle", bus.busy, 0);

    // 2-bit frame counter wrap on the second instance.
    for (int i = 0; i < 3; i++) push_byte(8'(8'h40 + i), 1'b0);
    wait_frames(3, "wrap_pre");
    check("wrap_3", bus2.frames_sent, 3);
    for (int i = 0; i < 3; i++) begin
      push_byte(8'(8'h50 + i), 1'b0);
      wait_frames(4 + i, "wrap_step");
      check("wrap_seq", bus2.frames_sent, wrap_exp[i]);
    end

    // Random traffic with inhibit bursts.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.push_valid      = ($urandom_range(0, 7) == 0);
      bus.push_data       = 8'($urandom);
      bus.push_bad_parity = ($urandom_range(0, 3) == 0);
      if (!bus.host_inhibit) bus.host_inhibit = ($urandom_range(0, 299) == 0);
      else bus.host_inhibit = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    bus.push_valid   = 1'b0;
    bus.host_inhibit = 1'b0;
    wait_idle("drain");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
